// File: rtl/grid_sequencer.sv
// grid_sequencer -- top-level controller for the 64-column heat-map grid.
// Issues a one-cycle compute start pulse per iteration and waits for the
// column done flag. Every DRAW_EVERY iterations, and after every single step,
// it opens a frame-aligned write-out window to the VGA colour memory.
// Supports free-run, single-step and pause.
// Optional feature: define GRID_SEQ_WDOG_EN to add a watchdog on COMPUTE and
// DRAW. On timeout it raises a sticky err and returns to IDLE after WDOG_CYC
// cycles. Without the macro, err is tied low.

module grid_sequencer #(
   parameter int ITER_W     = 16,
   parameter int DRAW_EVERY = 4,
   parameter int WDOG_CYC   = 4096
) (
   input  logic              clk_50,
   input  logic              reset,
   input  logic              run,
   input  logic              step,
   input  logic              frame_tick,
   input  logic              grid_flag,
   input  logic              done_write_sig,
   output logic              grid_start,
   output logic              write_sig,
   output logic [ITER_W-1:0] iter_count,
   output logic              busy,
   output logic [2:0]        state_out,
   output logic              err
);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_START      = 3'd1,
      ST_COMPUTE    = 3'd2,
      ST_ACCOUNT    = 3'd3,
      ST_WAIT_FRAME = 3'd4,
      ST_DRAW       = 3'd5
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(DRAW_EVERY - 1);

   state_t            r_state;
   logic              r_flag_q;
   logic              r_done_q;
   logic              r_frame_pending;
   logic              r_step_mode;
   logic              r_blank;
   logic              r_grid_start;
   logic              r_write_sig;
   logic [ITER_W-1:0] r_iter;
   logic [7:0]        r_div;

   logic              w_flag_rise;
   logic              w_done_rise;
   logic              w_frame_ready;
   logic              w_enter_draw;
   logic              w_can_start;

   assign w_flag_rise   = grid_flag & ~r_flag_q;
   assign w_done_rise   = done_write_sig & ~r_done_q;
   assign w_frame_ready = r_frame_pending | frame_tick;
   assign w_enter_draw  = (r_state == ST_WAIT_FRAME) && w_frame_ready;

`ifdef GRID_SEQ_WDOG_EN
   localparam int WD_W = $clog2(WDOG_CYC) + 1;

   logic            r_err;
   logic [WD_W-1:0] r_wdog;
   logic            w_wdog_to;

   assign w_wdog_to   = (r_wdog == WD_W'(WDOG_CYC - 1));
   assign w_can_start = (run | step) & ~r_err;
   assign err         = r_err;

   // Watchdog cycle counter: restarts on entry to COMPUTE or DRAW, counts while there.
   always_ff @(posedge clk_50 or negedge reset) begin
      if (!reset) begin
         r_wdog <= '0;
      end else if (r_state == ST_START || w_enter_draw) begin
         r_wdog <= '0;
      end else if (r_state == ST_COMPUTE || r_state == ST_DRAW) begin
         r_wdog <= r_wdog + WD_W'(1);
      end
   end
`else
   assign w_can_start = run | step;
   assign err         = 1'b0;
`endif

   // Single-register edge detectors for the done flags.
   always_ff @(posedge clk_50 or negedge reset) begin
      // NOTE: sequential state always uses non-blocking (<=) so every register
      // samples pre-edge values regardless of statement order.
      if (!reset) begin
         r_flag_q <= 1'b0;
         r_done_q <= 1'b0;
      end else begin
         r_flag_q <= grid_flag;
         r_done_q <= done_write_sig;
      end
   end

   // Frame request latch: set by a tick, consumed on DRAW entry; a
   // coincident tick wins over the clear.
   always_ff @(posedge clk_50 or negedge reset) begin
      if (!reset) begin
         r_frame_pending <= 1'b0;
      end else begin
         r_frame_pending <= frame_tick | (r_frame_pending & ~w_enter_draw);
      end
   end

   // Main sequencer FSM with registered outputs.
   always_ff @(posedge clk_50 or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_step_mode  <= 1'b0;
         r_blank      <= 1'b0;
         r_grid_start <= 1'b0;
         r_write_sig  <= 1'b0;
         r_iter       <= '0;
         r_div        <= '0;
`ifdef GRID_SEQ_WDOG_EN
         r_err        <= 1'b0;
`endif
      end else begin
         // NOTE: grid_start defaults low each cycle and is only raised on the
         // transition into START, so it can never stretch past one cycle.
         r_grid_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_can_start) begin
                  // run wins over a simultaneous step
                  r_step_mode  <= ~run;
                  r_grid_start <= 1'b1;
                  r_state      <= ST_START;
               end
            end
            ST_START: begin
               r_blank <= 1'b0;
               r_state <= ST_COMPUTE;
            end
            ST_COMPUTE: begin
               // first COMPUTE cycle is blanked to cover column flag latency
               r_blank <= 1'b1;
               if (r_blank && w_flag_rise) begin
                  r_state <= ST_ACCOUNT;
               end
`ifdef GRID_SEQ_WDOG_EN
               else if (w_wdog_to) begin
                  r_err       <= 1'b1;
                  r_step_mode <= 1'b0;
                  r_state     <= ST_IDLE;
               end
`endif
            end
            ST_ACCOUNT: begin
               r_iter <= r_iter + ITER_W'(1);
               if (r_step_mode || r_div == DIV_LAST) begin
                  r_div   <= '0;
                  r_state <= ST_WAIT_FRAME;
               end else begin
                  r_div <= r_div + 8'd1;
                  if (run) begin
                     r_grid_start <= 1'b1;
                     r_state      <= ST_START;
                  end else begin
                     r_step_mode <= 1'b0;
                     r_state     <= ST_IDLE;
                  end
               end
            end
            ST_WAIT_FRAME: begin
               if (w_frame_ready) begin
                  r_write_sig <= 1'b1;
                  r_state     <= ST_DRAW;
               end
            end
            ST_DRAW: begin
               if (w_done_rise) begin
                  r_write_sig <= 1'b0;
                  if (run && !r_step_mode) begin
                     r_grid_start <= 1'b1;
                     r_state      <= ST_START;
                  end else begin
                     r_step_mode <= 1'b0;
                     r_state     <= ST_IDLE;
                  end
               end
`ifdef GRID_SEQ_WDOG_EN
               else if (w_wdog_to) begin
                  r_err       <= 1'b1;
                  r_write_sig <= 1'b0;
                  r_step_mode <= 1'b0;
                  r_state     <= ST_IDLE;
               end
`endif
            end
            default: begin
               r_write_sig <= 1'b0;
               r_step_mode <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign grid_start = r_grid_start;
   assign write_sig  = r_write_sig;
   assign iter_count = r_iter;
   assign state_out  = r_state;
   assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_grid_sequencer.sv
// Self-checking bench for grid_sequencer. A reactive environment acknowledges
// compute starts, ticks frames and acknowledges write-out windows with
// randomized delays. A reference model tracks iterations, draw-pass counts
// and frame alignment at the transaction level.
// Define GRID_SEQ_WDOG_EN on both files to exercise the watchdog.

module tb_grid_sequencer;
   localparam int ITER_W     = 16;
   localparam int DRAW_EVERY = 4;
   localparam int WDOG_CYC   = 64;

   logic              clk_50 = 1'b0;
   logic              reset;
   logic              run;
   logic              step;
   logic              frame_tick;
   logic              grid_flag;
   logic              done_write_sig;
   logic              grid_start;
   logic              write_sig;
   logic [ITER_W-1:0] iter_count;
   logic              busy;
   logic [2:0]        state_out;
   logic              err;

   grid_sequencer #(
      .ITER_W    (ITER_W),
      .DRAW_EVERY(DRAW_EVERY),
      .WDOG_CYC  (WDOG_CYC)
   ) dut (
      .clk_50        (clk_50),
      .reset         (reset),
      .run           (run),
      .step          (step),
      .frame_tick    (frame_tick),
      .grid_flag     (grid_flag),
      .done_write_sig(done_write_sig),
      .grid_start    (grid_start),
      .write_sig     (write_sig),
      .iter_count    (iter_count),
      .busy          (busy),
      .state_out     (state_out),
      .err           (err)
   );

   always #10 clk_50 = ~clk_50;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
   endtask

   // environment controls
   bit auto_grid, auto_frame, auto_write;
   bit rand_grid, rand_write, rand_frame;
   bit chk_spd, trace_on, model_step;
   bit last_tick, prev_ws;
   int grid_cnt, write_cnt, frame_cnt, frame_period;
   int n_starts, starts_win, n_windows, ticks_win;
   // reference model
   logic [ITER_W-1:0] exp_iter;
   int exp_phase, exp_draws;
   // state trace
   logic [31:0] trace_val;
   logic [2:0]  trace_last;
   int          trace_len;

   // One completed iteration as seen by the environment.
   task automatic model_ack();
      exp_iter = exp_iter + 16'd1;
      if (model_step) begin
         exp_draws++;
         exp_phase  = 0;
         model_step = 0;
      end else begin
         exp_phase++;
         if (exp_phase == DRAW_EVERY) begin
            exp_phase = 0;
            exp_draws++;
         end
      end
   endtask

   // Advance one clock, observe outputs, then drive environment inputs.
   task automatic cycle();
      @(posedge clk_50);
      #1;
      if (grid_start === 1'b1) begin
         n_starts++;
         starts_win++;
         if (auto_grid) grid_cnt = rand_grid ? int'($urandom_range(2, 9)) : 5;
      end
      if (write_sig === 1'b1 && !prev_ws) begin
         n_windows++;
         check("frame_before_draw", longint'(ticks_win > 0), 1);
         check("draws_at_window", n_windows, exp_draws);
         check("iter_at_window", iter_count, exp_iter);
         if (chk_spd) check("starts_per_draw", starts_win, DRAW_EVERY);
         starts_win = 0;
         ticks_win  = last_tick ? 1 : 0;
         if (auto_write) write_cnt = rand_write ? int'($urandom_range(1, 80)) : 70;
      end
      prev_ws = (write_sig === 1'b1);
      if (trace_on && state_out !== trace_last) begin
         trace_val  = (trace_val << 3) | 32'(state_out);
         trace_last = state_out;
         trace_len++;
      end
      frame_tick = 1'b0;
      if (auto_frame) begin
         if (frame_cnt == 0) begin
            frame_tick = 1'b1;
            ticks_win++;
            frame_cnt = (rand_frame ? int'($urandom_range(20, 150)) : frame_period) - 1;
         end else begin
            frame_cnt--;
         end
      end
      last_tick = frame_tick;
      if (auto_grid) begin
         grid_flag = 1'b0;
         if (grid_cnt == 0) begin
            grid_flag = 1'b1;
            grid_cnt  = -1;
            model_ack();
         end else if (grid_cnt > 0) begin
            grid_cnt--;
         end
      end
      if (auto_write) begin
         done_write_sig = 1'b0;
         if (write_cnt == 0) begin
            done_write_sig = 1'b1;
            write_cnt      = -1;
         end else if (write_cnt > 0) begin
            write_cnt--;
         end
      end
   endtask

   // sel: 1 = grid_start, 2 = write_sig, 3 = idle (busy low)
   task automatic wait_for(input int sel, input int budget, input string tag);
      int  n = 0;
      bit  hit;
      hit = 0;
      while (n < budget) begin
         hit = (sel == 1) ? (grid_start === 1'b1) :
               (sel == 2) ? (write_sig === 1'b1) : (busy === 1'b0);
         if (hit) break;
         cycle();
         n++;
      end
      hit = (sel == 1) ? (grid_start === 1'b1) :
            (sel == 2) ? (write_sig === 1'b1) : (busy === 1'b0);
      check(tag, longint'(hit), 1);
   endtask

   task automatic clear_model();
      grid_cnt   = -1;
      write_cnt  = -1;
      frame_cnt  = frame_period - 1;
      exp_iter   = '0;
      exp_phase  = 0;
      exp_draws  = 0;
      n_windows  = 0;
      starts_win = 0;
      ticks_win  = 0;
      last_tick  = 0;
      prev_ws    = 0;
      model_step = 0;
   endtask

   task automatic do_reset();
      run = 0; step = 0; grid_flag = 0; done_write_sig = 0; frame_tick = 0;
      auto_grid = 0; auto_frame = 0; auto_write = 0;
      reset = 1'b0;
      cycle();
      cycle();
      reset = 1'b1;
      clear_model();
   endtask

   initial begin
      int n;
      int base;
      int exp_tr [6];
      logic [31:0] exp_trace;

      reset = 1'b0; run = 0; step = 0; frame_tick = 0; grid_flag = 0; done_write_sig = 0;
      auto_grid = 0; auto_frame = 0; auto_write = 0;
      rand_grid = 0; rand_write = 0; rand_frame = 0;
      chk_spd = 0; trace_on = 0; trace_val = '0; trace_last = 3'd0; trace_len = 0;
      n_starts = 0; frame_period = 200;
      clear_model();

      // ---- reset state
      cycle();
      cycle();
      check("rst_grid_start", grid_start, 0);
      check("rst_write_sig", write_sig, 0);
      check("rst_iter_count", iter_count, 0);
      check("rst_busy", busy, 0);
      check("rst_state", state_out, 0);
      check("rst_err", err, 0);
      do_reset();

      // ---- free-run with fixed environment timing
      frame_period = 200; frame_cnt = 199;
      auto_grid = 1; auto_frame = 1; auto_write = 1; chk_spd = 1;
      run = 1;
      n = 0;
      while (n_windows < 2 && n < 5000) begin cycle(); n++; end
      check("two_draws_reached", n_windows, 2);
      check("iter_after_2_draws", iter_count, 8);

      // ---- free-run with randomized environment timing, then pause
      rand_grid = 1; rand_write = 1; rand_frame = 1;
      n = 0;
      while (n_windows < 6 && n < 10000) begin cycle(); n++; end
      check("six_draws_reached", n_windows, 6);
      run = 0;
      wait_for(3, 2000, "pause_to_idle");
      check("pause_iter", iter_count, exp_iter);
      check("pause_draws", n_windows, exp_draws);
      chk_spd = 0;

      // ---- single step, second step during DRAW ignored
      do_reset();
      auto_grid = 1; auto_frame = 1; auto_write = 1;
      base = n_starts;
      trace_on = 1; trace_val = '0; trace_last = 3'd0; trace_len = 0;
      model_step = 1;
      step = 1;
      cycle();
      step = 0;
      wait_for(2, 600, "step_draw_open");
      step = 1;
      cycle();
      step = 0;
      wait_for(3, 600, "step_back_idle");
      repeat (20) cycle();
      trace_on = 0;
      exp_tr = '{1, 2, 3, 4, 5, 0};
      exp_trace = '0;
      for (int i = 0; i < 6; i++) exp_trace = (exp_trace << 3) | 32'(exp_tr[i]);
      check("step_trace_len", trace_len, 6);
      check("step_trace", trace_val, exp_trace);
      check("step_one_start", n_starts - base, 1);
      check("step_one_draw", n_windows, 1);
      check("step_iter", iter_count, 1);
      check("step_busy", busy, 0);

      // ---- blanking window and mid-run pause
      do_reset();
      auto_frame = 1; auto_write = 1;
      run = 1;
      wait_for(1, 10, "blank_first_start");
      grid_flag = 1;                       // rise during START
      cycle();
      grid_flag = 0;
      repeat (5) cycle();
      check("blank_start_ignored", state_out, 2);
      grid_flag = 1;
      cycle();
      grid_flag = 0;
      model_ack();
      check("rise_to_account", state_out, 3);
      wait_for(1, 10, "blank_second_start");
      cycle();                             // first COMPUTE cycle
      grid_flag = 1;
      run = 0;
      cycle();
      grid_flag = 0;
      repeat (3) cycle();
      check("blank_compute1_ignored", state_out, 2);
      base = n_starts;
      grid_flag = 1;
      cycle();
      grid_flag = 0;
      model_ack();
      wait_for(3, 20, "pause_after_account");
      repeat (10) cycle();
      check("pause_iter2", iter_count, 2);
      check("pause_no_draw", n_windows, 0);
      check("pause_no_start", n_starts - base, 0);

      // ---- run+step together, then stuck acknowledge
      do_reset();
      auto_grid = 1; auto_frame = 1;
      base = n_starts;
      run = 1; step = 1;
      cycle();
      step = 0;
      check("run_step_start", state_out, 1);
      n = 0;
      while (n_starts - base < 2 && n < 60) begin cycle(); n++; end
      check("run_step_second_start", n_starts - base, 2);
      check("run_step_no_draw", n_windows, 0);
      done_write_sig = 1;
      wait_for(2, 600, "stuck_draw_open");
      repeat (20) cycle();
      check("stuck_ack_holds", write_sig, 1);
      done_write_sig = 0;
      run = 0;
      cycle();
      check("ack_low_holds", write_sig, 1);
      done_write_sig = 1;
      cycle();
      check("ack_rise_releases", write_sig, 0);
      done_write_sig = 0;
      wait_for(3, 10, "stuck_back_idle");
      check("stuck_iter", iter_count, 4);

      // ---- asynchronous reset while in DRAW
      run = 1;
      wait_for(2, 1000, "rst_draw_open");
      #5;
      reset = 1'b0;
      #1;
      check("midrst_write_sig", write_sig, 0);
      check("midrst_iter", iter_count, 0);
      check("midrst_state", state_out, 0);
      check("midrst_grid_start", grid_start, 0);
      auto_grid = 0; grid_flag = 0; run = 0;
      cycle();
      cycle();
      reset = 1'b1;
      clear_model();
      base = n_starts;
      repeat (30) cycle();
      check("post_rst_no_start", n_starts - base, 0);
      check("post_rst_busy", busy, 0);

`ifdef GRID_SEQ_WDOG_EN
      // ---- watchdog: grid_flag never rises
      do_reset();
      run = 1;
      wait_for(1, 10, "wdog_start");
      cycle();                             // now past the COMPUTE entry edge
      repeat (63) cycle();
      check("wdog_not_early", err, 0);
      cycle();
      check("wdog_err", err, 1);
      check("wdog_idle", state_out, 0);
      base = n_starts;
      repeat (20) cycle();
      check("wdog_run_ignored", n_starts - base, 0);
      check("wdog_err_sticky", err, 1);
      run = 0;
`else
      check("err_tied_low", err, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/grid_sequencer.md
Name: grid_sequencer

Overview:
- Top-level controller for the 64-column heat-map grid datapath. It issues the one-cycle compute start pulse and waits for the column done flag.
- Every DRAW_EVERY iterations it opens a write-out window to the VGA colour memory, aligned to a frame tick.
- Supports free-run, single-step and pause, and exposes an iteration count and status to the HPS/debug logic.

Parameters:
- ITER_W, 16, width of the iteration counter.
- DRAW_EVERY, 4, compute iterations per write-out pass (legal range 1..255).
- WDOG_CYC, 4096, watchdog limit in cycles (used only when WDOG_EN is defined).

Ports:
- clk_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = free-run iterations.
- step  in  1  one-cycle pulse; requests exactly one iteration while run = 0.
- frame_tick  in  1  one-cycle pulse per VGA frame (vsync).
- grid_flag  in  1  column-0 done flag; a rising edge means the iteration is complete.
- done_write_sig  in  1  write-out complete; a rising edge is the acknowledgement.
- grid_start  out  1  one-cycle start pulse to all columns.
- write_sig  out  1  level enable for the write-out sweep.
- iter_count  out  ITER_W  completed iterations.
- busy  out  1  high in any state other than IDLE.
- state_out  out  3  current state encoding.
- err  out  1  sticky watchdog error.

Behaviour:
- Reset (reset = 0, asynchronous):
  - Outputs: grid_start = 0, write_sig = 0, iter_count = 0, busy = 0, err = 0, state = IDLE.
  - Internal: edge-detect registers = 0, draw divider = 0, frame_pending = 0.
  - Reset asserted mid-operation aborts immediately. No pending request survives reset.
- Edge detection: grid_flag and done_write_sig are each registered once. A rise is the current sample = 1 while the previous sample = 0.
- frame_pending:
  - Set by frame_tick.
  - Cleared when DRAW is entered.
  - A tick arriving in the same cycle as the clear re-sets it.
- State encoding: IDLE = 0, START = 1, COMPUTE = 2, ACCOUNT = 3, WAIT_FRAME = 4, DRAW = 5.
- IDLE:
  - If run = 1, go to START.
  - Otherwise, if step = 1, latch step_mode = 1 and go to START.
  - If run and step arrive together, run wins and the step is discarded.
- START: grid_start = 1 for exactly this cycle, then go to COMPUTE.
- COMPUTE:
  - Wait for a grid_flag rise. Rises seen in START or in the first cycle of COMPUTE are ignored; this is a 2-cycle blanking window covering column flag latency.
  - On a qualifying rise, go to ACCOUNT.
- ACCOUNT (1 cycle):
  - iter_count increments and wraps from all-ones to 0.
  - The draw divider increments. When it equals DRAW_EVERY - 1, reset it to 0 and go to WAIT_FRAME.
  - Otherwise go to START if run = 1 and step_mode = 0; else go to IDLE and clear step_mode.
  - A single step always forces a draw: it goes to WAIT_FRAME and the divider is cleared.
- WAIT_FRAME: when frame_pending = 1 (including a frame_tick in this same cycle), go to DRAW.
- DRAW:
  - write_sig = 1 from entry until a done_write_sig rise is sampled. write_sig deasserts on the following edge.
  - Next state: START if run = 1 and step_mode = 0; else IDLE, with step_mode cleared.
  - A done_write_sig already high on entry gives no rise and is not taken as an acknowledgement.
- Pause: run dropping during START, COMPUTE, WAIT_FRAME or DRAW does not abort. The current iteration and any due draw complete, then the sequencer goes to IDLE.
- Ignored inputs: step outside IDLE is ignored, with no queuing. frame_tick outside WAIT_FRAME only sets frame_pending.
- busy = (state != IDLE). state_out = state, registered.

Optional Feature:
- Macro: GRID_SEQ_WDOG_EN.
- Defined:
  - A cycle counter clears on entry to COMPUTE or DRAW.
  - If the counter reaches WDOG_CYC while still in that state, set err = 1 (sticky until reset), deassert write_sig and go to IDLE.
  - While err = 1, run and step are ignored.
- Not defined: no counter exists, err is tied to 0, and COMPUTE and DRAW wait indefinitely.

Test Plan:
- Free-run sequence: reset release, run = 1, bench acks grid_flag 5 cycles after each start, frame_tick every 200 cycles, done_write_sig rise 70 cycles into DRAW.
  - Exactly 4 grid_start pulses per write_sig window.
  - iter_count = 8 after 2 draws.
  - write_sig is never high before a frame_tick.
- Single step: run = 0, one step pulse.
  - One grid_start, then WAIT_FRAME, DRAW, IDLE.
  - iter_count = 1; busy returns to 0.
  - A second step pulse during DRAW is ignored, with no extra start.
- Blanking and mid-run pause:
  - A grid_flag rise in the START cycle is ignored; only a later rise advances to ACCOUNT.
  - run dropped in COMPUTE at iteration 2: the sequencer goes to IDLE after ACCOUNT with iter_count = 2 and no draw.
- Stuck acknowledge and simultaneous inputs:
  - done_write_sig held high before DRAW: write_sig stays high until the bench drops it and raises it again.
  - run and step asserted in the same cycle: a free-run start with step_mode = 0.
- Reset mid-operation: assert reset while in DRAW with write_sig = 1.
  - Same cycle: write_sig = 0, iter_count = 0, state_out = 0.
  - After release with run = 0: no grid_start is issued.
- Watchdog (GRID_SEQ_WDOG_EN defined, WDOG_CYC = 64): grid_flag never rises.
  - err = 1 exactly 64 cycles after entering COMPUTE; state then IDLE.
  - A subsequent run = 1 produces no grid_start.
